// File: rtl/nibble_serial_alu_seq.sv
// Area-reduced WIDTH-bit add/subtract: one shared 4-bit adder stepped LSB nibble first,
// with the inter-nibble carry held in a register; valid/ready on both sides.
module nibble_serial_alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovfl,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_width_check
        $error("nibble_serial_alu_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;     // already inverted for subtract
    logic              c_q;
    logic [CntW-1:0]   cnt_q;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        nib_sum;
    logic [WIDTH-1:0]  result_nx;
    logic              last_nib;

    // Shared 4-bit full adder
    always_comb begin
        a_nib   = 4'(a_q >> {cnt_q, 2'b00});
        b_nib   = 4'(b_q >> {cnt_q, 2'b00});
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
    end

    always_comb begin
        result_nx = result;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt_q == CntW'(i)) begin
                result_nx[4*i +: 4] = nib_sum[3:0];
            end
        end
        last_nib = (cnt_q == CntW'(NIBBLES - 1));
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            carry   <= 1'b0;
            ovfl    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b ^ {WIDTH{sub}};
                        c_q     <= sub;
                        cnt_q   <= '0;
                        result  <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    result <= result_nx;
                    c_q    <= nib_sum[4];
                    if (last_nib) begin
                        cnt_q   <= '0;
                        carry   <= nib_sum[4];
                        ovfl    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (result_nx[WIDTH-1] != a_q[WIDTH-1]);
                        zero    <= (result_nx == '0);
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Randomized bench for nibble_serial_alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         ovfl;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .ovfl      (ovfl),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic z);
        int unsigned ua, ub, full;
        int          sa, sb, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            full = ua + (32'hFFFF - ub) + 1;
            sres = sa - sb;
        end else begin
            full = ua + ub;
            sres = sa + sb;
        end
        r = full[W-1:0];
        c = full[W];
        v = (sres > 32767) || (sres < -32768);
        z = (r == '0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold);
        logic [W-1:0] er;
        logic         ec, ev, ez;
        int           lat;
        model(a, b, s, er, ec, ev, ez);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        sub      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_run", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("result", 32'(result), 32'(er));
        check("carry", 32'(carry), 32'(ec));
        check("ovfl", 32'(ovfl), 32'(ev));
        check("zero", 32'(zero), 32'(ez));
        // Back-pressure with a competing request that must not be captured
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(er));
            check("hold_flags", 32'({carry, ovfl, zero}), 32'({ec, ev, ez}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("idle_result_kept", 32'(result), 32'(er));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry, ovfl, zero}), 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'h0005, 16'h0005, 1'b1, 0);
        run_op(16'h0003, 16'h0005, 1'b1, 3);

        // Reset in the middle of RUN
        op_a     = 16'hABCD;
        op_b     = 16'h1111;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_emit", 32'(out_valid), 32'd0);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        // Edge-biased operands
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x, y;
            x = (i[0]) ? 16'h8000 : 16'h7FFF;
            y = (i[1]) ? 16'hFFFF : 16'h0000;
            run_op(x, y, i[2], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
